ibex_imem_arbiter: RTL and testbench

Single-port arbiter and boot sequencer for the instruction memory. It shares one IMEM port between the host loader port (program download) and the core instruction-fetch port. It holds the core in reset-equivalent stall until loading completes, then raises fetch enable. It converts the memory's fixed 1-cycle read latency into req/gnt/rvalid handshakes on both ports.

---
 rtl/ibex_imem_arb_pkg.sv | 26 ++
 rtl/ibex_imem_arb_starve_ctr.sv | 32 +++
 rtl/ibex_imem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ibex_imem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_imem_arb_pkg.sv
// Shared types and defaults for the IMEM arbiter / boot sequencer.
package ibex_imem_arb_pkg;

    // Boot sequencer state: LOAD holds the core off the memory, RUN arbitrates.
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    // Which port owns the response returned one cycle after a grant.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_CORE = 2'd2,
        OWN_ERR  = 2'd3
    } rsp_owner_e;

    localparam int unsigned DEF_ADDR_W     = 8;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam logic [31:0] DEF_BASE_ADDR  = 32'h0000_0000;
    localparam int unsigned DEF_STARVE_MAX = 4;

    // Wide enough for the largest legal STARVE_MAX (15).
    localparam int unsigned STARVE_CTR_W   = 4;

endpackage

// File: rtl/ibex_imem_arb_starve_ctr.sv
// Saturating starvation counter: counts host wins while the core waits.
// Clear has priority over increment; o_at_max flags the forced core turn.
module ibex_imem_arb_starve_ctr
    import ibex_imem_arb_pkg::*;
#(
    parameter int unsigned MAX = DEF_STARVE_MAX
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_max
);

    localparam logic [STARVE_CTR_W-1:0] L_MAX = STARVE_CTR_W'(MAX);

    logic [STARVE_CTR_W-1:0] r_cnt;

    // Count host grants, hold at MAX, clear when the core is served.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != L_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == L_MAX);

endmodule

// File: rtl/ibex_imem_arbiter.sv
// Single-port IMEM arbiter and boot sequencer.
// Shares one IMEM port between the host loader and core instruction fetch,
// holds off core fetch until load_done_i, and turns the fixed 1-cycle memory
// read latency into req/gnt/rvalid handshakes.
// Handshake: a port's gnt is combinational in the cycle its req is high and it
// wins; rvalid follows exactly one cycle after gnt. Requesters hold req until gnt.
// Optional feature macro: IMEM_ARB_RANGE_CHK_EN (core address range/alignment check).
module ibex_imem_arbiter
    import ibex_imem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    input  logic              load_done_i,
    output logic              fetch_enable_o,
    input  logic              instr_req_i,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rdata_o,
    output logic              instr_err_o,
    output logic              mem_cen_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_fetch_en;
    rsp_owner_e        r_owner;
    rsp_owner_e        w_owner_nxt;
    logic              r_rsp_wr;
    logic              w_host_gnt;
    logic              w_instr_gnt;
    logic              w_core_force;
    logic              w_core_err;
    logic              w_at_max;
    logic              w_cnt_inc;
    logic [31:0]       w_core_off;
    logic [ADDR_W-1:0] w_core_word;
    logic              w_unused_off;

    // Core byte address -> IMEM word index relative to BASE_ADDR.
    assign w_core_off   = instr_addr_i - BASE_ADDR;
    assign w_core_word  = w_core_off[ADDR_W+1:2];
    // Bits outside the word index only matter to the optional range check.
    assign w_unused_off = ^{w_core_off[31:ADDR_W+2], w_core_off[1:0]};

`ifdef IMEM_ARB_RANGE_CHK_EN
    // Misaligned, below the window, or past the last IMEM word.
    assign w_core_err = (instr_addr_i[1:0] != 2'b00)
                      | (instr_addr_i < BASE_ADDR)
                      | ((w_core_off >> (ADDR_W + 2)) != 32'd0);
`else
    assign w_core_err = 1'b0;
`endif

    // Starvation tracking only matters once both ports compete in RUN.
    assign w_cnt_inc = w_host_gnt & instr_req_i & (r_state == ST_RUN);

    ibex_imem_arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_clr    (w_instr_gnt),
        .i_inc    (w_cnt_inc),
        .o_at_max (w_at_max)
    );

    // State register plus registered fetch enable (falls asynchronously on reset).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_LOAD;
            r_fetch_en <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_en <= (w_state_nxt == ST_RUN);
        end
    end

    // Next state: leave LOAD once the loader signals completion; RUN is sticky.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: if (load_done_i) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    // Grants, memory drive and the response owner for the next cycle.
    always_comb begin
        w_host_gnt   = 1'b0;
        w_instr_gnt  = 1'b0;
        w_core_force = 1'b0;
        mem_cen_o    = 1'b0;
        mem_wen_o    = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        w_owner_nxt  = OWN_NONE;
        case (r_state)
            ST_LOAD: begin
                w_host_gnt = host_req_i;
            end
            ST_RUN: begin
                w_core_force = instr_req_i & w_at_max;
                w_host_gnt   = host_req_i & ~w_core_force;
                w_instr_gnt  = instr_req_i & (~host_req_i | w_core_force);
            end
            default: ;
        endcase
        if (w_host_gnt) begin
            mem_cen_o   = 1'b1;
            mem_wen_o   = host_we_i;
            mem_addr_o  = host_addr_i;
            mem_wdata_o = host_wdata_i;
            w_owner_nxt = OWN_HOST;
        end else if (w_instr_gnt) begin
            if (w_core_err) begin
                w_owner_nxt = OWN_ERR;
            end else begin
                mem_cen_o   = 1'b1;
                mem_addr_o  = w_core_word;
                w_owner_nxt = OWN_CORE;
            end
        end
    end

    // Response owner lives for exactly one cycle after each grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner  <= OWN_NONE;
            r_rsp_wr <= 1'b0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_rsp_wr <= w_host_gnt & host_we_i;
        end
    end

    // Route memory read data to the owning port; the other port sees zero.
    always_comb begin
        host_rvalid_o  = (r_owner == OWN_HOST);
        host_rdata_o   = ((r_owner == OWN_HOST) && !r_rsp_wr) ? mem_rdata_i : '0;
        instr_rvalid_o = (r_owner == OWN_CORE) || (r_owner == OWN_ERR);
        instr_rdata_o  = (r_owner == OWN_CORE) ? mem_rdata_i : '0;
        instr_err_o    = (r_owner == OWN_ERR);
    end

    assign host_gnt_o     = w_host_gnt;
    assign instr_gnt_o    = w_instr_gnt;
    assign fetch_enable_o = r_fetch_en;

endmodule

// File: tb/tb_ibex_imem_arbiter.sv
// Self-checking bench for ibex_imem_arbiter with a behavioural 1-cycle IMEM.
module tb_ibex_imem_arbiter;
    import ibex_imem_arb_pkg::*;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int unsigned STARVE = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              host_req_i;
    logic              host_we_i;
    logic [ADDR_W-1:0] host_addr_i;
    logic [DATA_W-1:0] host_wdata_i;
    logic              host_gnt_o;
    logic              host_rvalid_o;
    logic [DATA_W-1:0] host_rdata_o;
    logic              load_done_i;
    logic              fetch_enable_o;
    logic              instr_req_i;
    logic [31:0]       instr_addr_i;
    logic              instr_gnt_o;
    logic              instr_rvalid_o;
    logic [DATA_W-1:0] instr_rdata_o;
    logic              instr_err_o;
    logic              mem_cen_o;
    logic              mem_wen_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    ibex_imem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .BASE_ADDR  (BASE),
        .STARVE_MAX (STARVE)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .host_req_i     (host_req_i),
        .host_we_i      (host_we_i),
        .host_addr_i    (host_addr_i),
        .host_wdata_i   (host_wdata_i),
        .host_gnt_o     (host_gnt_o),
        .host_rvalid_o  (host_rvalid_o),
        .host_rdata_o   (host_rdata_o),
        .load_done_i    (load_done_i),
        .fetch_enable_o (fetch_enable_o),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .mem_cen_o      (mem_cen_o),
        .mem_wen_o      (mem_wen_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- IMEM model: 1-cycle read latency ----------------
    logic [DATA_W-1:0] imem [0:(1<<ADDR_W)-1];
    always @(posedge clk_i) begin
        if (mem_cen_o) begin
            if (mem_wen_o) imem[mem_addr_o] <= mem_wdata_o;
            mem_rdata_i <= imem[mem_addr_o];
        end
    end

    // ---------------- scoreboard state ----------------
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W:0]   host_exp_q[$];   // {err, data}
    logic [DATA_W:0]   core_exp_q[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    logic              last_hgnt;
    logic              last_ignt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {err, data} for a core fetch of byte address a.
    function automatic logic [DATA_W:0] core_exp(input logic [31:0] a);
        logic [31:0]       off;
        logic [ADDR_W-1:0] w;
        logic              err;
        off = a - BASE;
        w   = off[ADDR_W+1:2];
        err = 1'b0;
`ifdef IMEM_ARB_RANGE_CHK_EN
        begin
            logic [63:0] lim;
            lim = 64'(BASE) + (64'd4 << ADDR_W);
            if ((a[1:0] != 2'b00) || (a < BASE) || (64'(a) >= lim)) err = 1'b1;
        end
`endif
        return err ? {1'b1, {DATA_W{1'b0}}} : {1'b0, ref_mem[w]};
    endfunction

    // One cycle: check responses due now, record/verify grants, advance to #1 after posedge.
    task automatic step();
        logic [DATA_W:0]   e;
        logic [31:0]       off;
        @(negedge clk_i);
        check("host_rvalid", host_rvalid_o, host_exp_q.size() != 0);
        if (host_exp_q.size() != 0) begin
            e = host_exp_q.pop_front();
            check("host_rdata", host_rdata_o, e[DATA_W-1:0]);
        end else begin
            check("host_rdata_idle", host_rdata_o, 0);
        end
        check("instr_rvalid", instr_rvalid_o, core_exp_q.size() != 0);
        if (core_exp_q.size() != 0) begin
            e = core_exp_q.pop_front();
            check("instr_rdata", instr_rdata_o, e[DATA_W-1:0]);
            check("instr_err", instr_err_o, e[DATA_W]);
        end else begin
            check("instr_rdata_idle", instr_rdata_o, 0);
            check("instr_err_idle", instr_err_o, 0);
        end
        check("one_gnt", host_gnt_o & instr_gnt_o, 0);
        last_hgnt = host_gnt_o;
        last_ignt = instr_gnt_o;
        if (host_gnt_o) begin
            check("host_mem_drive", {mem_cen_o, mem_wen_o, mem_addr_o, mem_wdata_o},
                  {1'b1, host_we_i, host_addr_i, host_wdata_i});
            host_exp_q.push_back(host_we_i ? '0 : {1'b0, ref_mem[host_addr_i]});
            if (host_we_i) ref_mem[host_addr_i] = host_wdata_i;
        end else if (instr_gnt_o) begin
            e   = core_exp(instr_addr_i);
            off = instr_addr_i - BASE;
            if (e[DATA_W])
                check("err_mem_idle", {mem_cen_o, mem_wen_o, mem_addr_o, mem_wdata_o}, 0);
            else
                check("core_mem_drive", {mem_cen_o, mem_wen_o, mem_addr_o, mem_wdata_o},
                      {1'b1, 1'b0, off[ADDR_W+1:2], {DATA_W{1'b0}}});
            core_exp_q.push_back(e);
        end else begin
            check("mem_idle", {mem_cen_o, mem_wen_o, mem_addr_o, mem_wdata_o}, 0);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_host_gnt"}, host_gnt_o, 0);
        check({tag, "_host_rvalid"}, host_rvalid_o, 0);
        check({tag, "_host_rdata"}, host_rdata_o, 0);
        check({tag, "_fetch_en"}, fetch_enable_o, 0);
        check({tag, "_instr_gnt"}, instr_gnt_o, 0);
        check({tag, "_instr_rvalid"}, instr_rvalid_o, 0);
        check({tag, "_instr_rdata"}, instr_rdata_o, 0);
        check({tag, "_instr_err"}, instr_err_o, 0);
        check({tag, "_mem_cen"}, mem_cen_o, 0);
        check({tag, "_mem_wen"}, mem_wen_o, 0);
        check({tag, "_mem_addr"}, mem_addr_o, 0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 0);
    endtask

    task automatic drive_idle();
        host_req_i   = 1'b0;
        host_we_i    = 1'b0;
        host_addr_i  = '0;
        host_wdata_i = '0;
        load_done_i  = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] range_addrs [4];
        int          core_wait;
        logic        hreq_now;
        logic        ireq_now;

        drive_idle();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_quiet("in_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_quiet("post_reset");
        check("state_reset", dut.r_state, ST_LOAD);

        // Program download: fill all of IMEM while the core is already asking.
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_000C;
        for (int w = 0; w < (1 << ADDR_W); w++) begin
            host_req_i   = 1'b1;
            host_we_i    = 1'b1;
            host_addr_i  = ADDR_W'(w);
            host_wdata_i = $urandom;
            step();
            check("load_hgnt", last_hgnt, 1);
            check("load_no_igrant", last_ignt, 0);
        end
        // Word 3 <- DEADBEEF with core still requesting.
        host_addr_i  = 8'd3;
        host_wdata_i = 32'hDEAD_BEEF;
        step();
        check("wr3_hgnt", last_hgnt, 1);
        check("wr3_igrant", last_ignt, 0);
        check("wr3_fetch_en", fetch_enable_o, 0);
        // load_done in the same cycle as a host grant.
        host_addr_i  = 8'd20;
        host_wdata_i = $urandom;
        load_done_i  = 1'b1;
        step();
        check("ld_hgnt", last_hgnt, 1);
        check("ld_igrant", last_ignt, 0);
        check("fetch_en_rise", fetch_enable_o, 1);
        load_done_i = 1'b0;
        host_req_i  = 1'b0;
        host_we_i   = 1'b0;
        // Core fetch of 0xC (expects DEADBEEF next cycle via scoreboard).
        step();
        check("core_c_gnt", last_ignt, 1);
        check("core_c_ref", ref_mem[3], 32'hDEAD_BEEF);
        instr_req_i = 1'b0;
        step();

        // Back-to-back core fetches 0x0, 0x4, 0x8.
        for (int i = 0; i < 3; i++) begin
            instr_req_i  = 1'b1;
            instr_addr_i = 32'(i * 4);
            step();
            check("seq_igrant", last_ignt, 1);
        end
        instr_req_i = 1'b0;
        step();

        // Both ports held: STARVE host grants, then one core grant, repeating.
        host_req_i   = 1'b1;
        host_we_i    = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0010;
        for (int i = 0; i < 15; i++) begin
            host_addr_i = ADDR_W'(i + 40);
            step();
            check("arb_hgnt", last_hgnt, (i % (STARVE + 1)) != STARVE);
            check("arb_igrant", last_ignt, (i % (STARVE + 1)) == STARVE);
        end
        host_req_i  = 1'b0;
        instr_req_i = 1'b0;
        step();

        // Boundary core addresses (error or truncation depending on build).
        range_addrs[0] = 32'h0000_0400;
        range_addrs[1] = 32'h0000_0005;
        range_addrs[2] = 32'h0000_03FC;
        range_addrs[3] = 32'hFFFF_FFFC;
        for (int i = 0; i < 4; i++) begin
            instr_req_i  = 1'b1;
            instr_addr_i = range_addrs[i];
            step();
            check("range_igrant", last_ignt, 1);
            instr_req_i = 1'b0;
            step();
        end

        // Random mixed traffic; requests held until granted.
        core_wait = 0;
        for (int c = 0; c < 80; c++) begin
            hreq_now = host_req_i;
            ireq_now = instr_req_i;
            step();
            if (hreq_now || ireq_now) check("rnd_any_gnt", last_hgnt | last_ignt, 1);
            if (ireq_now && !last_ignt) core_wait++;
            else core_wait = 0;
            check("rnd_starve", core_wait > int'(STARVE), 0);
            if (!host_req_i || last_hgnt) begin
                host_req_i   = 1'($urandom_range(0, 1));
                host_we_i    = 1'($urandom_range(0, 1));
                host_addr_i  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
                host_wdata_i = $urandom;
            end
            if (!instr_req_i || last_ignt) begin
                instr_req_i  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0)
                    instr_addr_i = $urandom;
                else
                    instr_addr_i = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
        end
        drive_idle();
        step();
        step();

        // Reset right after a core grant: the pending response must vanish.
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0008;
        @(negedge clk_i);
        check("rst_pre_igrant", instr_gnt_o, 1);
        check("rst_pre_fetch_en", fetch_enable_o, 1);
        rst_ni      = 1'b0;
        instr_req_i = 1'b0;
        #1;
        check_quiet("rst_async");
        @(posedge clk_i);
        #1;
        check_quiet("rst_hold");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_quiet("rst_release");
        check("state_after_rst", dut.r_state, ST_LOAD);
        // Back in LOAD: core request must not be granted.
        instr_req_i = 1'b1;
        step();
        check("rst_load_igrant", last_ignt, 0);
        instr_req_i = 1'b0;
        step();

        check("drain_host_q", host_exp_q.size(), 0);
        check("drain_core_q", core_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
